// File: rtl/scan_capture_ctrl.sv
// Scan test controller: shifts patterns into a pseudo-primary chain, captures core response, compacts it in an 8-bit MISR.
// Latency: num_patterns*(CHAIN_LEN+1)+CHAIN_LEN cycles from accepted start to the done pulse (num_patterns=0: done next cycle).
// Backpressure: none; start is only honoured in IDLE and is dropped while a run is in progress.
module scan_capture_ctrl #(
  parameter int CHAIN_LEN = 2,
  parameter int SIG_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [7:0]           num_patterns,
  input  logic                 scan_in,
  input  logic [CHAIN_LEN-1:0] ppo,
  output logic [CHAIN_LEN-1:0] ppi,
  output logic                 scan_en,
  output logic                 scan_out,
  output logic                 busy,
  output logic                 done,
  output logic [SIG_W-1:0]     signature
);

  localparam int CNT_W = (CHAIN_LEN > 2) ? $clog2(CHAIN_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(CHAIN_LEN - 1);
  // Feedback taps for x^8+x^4+x^3+x^2+1
  localparam logic [SIG_W-1:0] POLY = SIG_W'(8'h1D);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SHIFT   = 3'd1,
    CAPTURE = 3'd2,
    UNLOAD  = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [CHAIN_LEN-1:0]   chain_q, chain_d;
  logic [SIG_W-1:0]       sig_q, sig_d;
  logic [7:0]             pat_cnt_q, pat_cnt_d;
  logic [CNT_W-1:0]       shift_cnt_q, shift_cnt_d;
  logic                   capture_seen_q, capture_seen_d;
  logic [SIG_W-1:0]       sig_step;

  // One MISR step folds in the bit currently leaving the chain (before the shift).
  always_comb begin
    sig_step = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ {{(SIG_W-1){1'b0}}, chain_q[CHAIN_LEN-1]};
  end

  // Next-state, chain, counter and signature update.
  always_comb begin
    state_d        = state_q;
    chain_d        = chain_q;
    sig_d          = sig_q;
    pat_cnt_d      = pat_cnt_q;
    shift_cnt_d    = shift_cnt_q;
    capture_seen_d = capture_seen_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sig_d = '0;
          if (num_patterns != 8'd0) begin
            state_d        = SHIFT;
            pat_cnt_d      = num_patterns;
            shift_cnt_d    = '0;
            capture_seen_d = 1'b0;
          end else begin
            state_d = DONE;
          end
        end
      end
      SHIFT: begin
        // The first load shifts out stale chain contents, so it is not compacted.
        if (capture_seen_q) sig_d = sig_step;
        chain_d = {chain_q[CHAIN_LEN-2:0], scan_in};
        if (shift_cnt_q == LAST_SHIFT) begin
          shift_cnt_d = '0;
          state_d     = CAPTURE;
        end else begin
          shift_cnt_d = shift_cnt_q + 1'b1;
        end
      end
      CAPTURE: begin
        chain_d        = ppo;
        pat_cnt_d      = pat_cnt_q - 8'd1;
        capture_seen_d = 1'b1;
        state_d        = (pat_cnt_q > 8'd1) ? SHIFT : UNLOAD;
      end
      UNLOAD: begin
        sig_d   = sig_step;
        chain_d = {chain_q[CHAIN_LEN-2:0], 1'b0};
        if (shift_cnt_q == LAST_SHIFT) begin
          shift_cnt_d = '0;
          state_d     = DONE;
        end else begin
          shift_cnt_d = shift_cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset aborts any run in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      chain_q        <= '0;
      sig_q          <= '0;
      pat_cnt_q      <= '0;
      shift_cnt_q    <= '0;
      capture_seen_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      chain_q        <= chain_d;
      sig_q          <= sig_d;
      pat_cnt_q      <= pat_cnt_d;
      shift_cnt_q    <= shift_cnt_d;
      capture_seen_q <= capture_seen_d;
    end
  end

  // Outputs decode directly from state so reset clears them without waiting for a clock.
  always_comb begin
    ppi       = chain_q;
    scan_out  = chain_q[CHAIN_LEN-1];
    signature = sig_q;
    scan_en   = (state_q == SHIFT) || (state_q == UNLOAD);
    busy      = (state_q == SHIFT) || (state_q == CAPTURE) || (state_q == UNLOAD);
    done      = (state_q == DONE);
  end

endmodule

// File: doc/scan_capture_ctrl.md
SCAN_CAPTURE_CTRL -- requirements
Module: scan_capture_ctrl

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 2, number of pseudo-primary flip-flops (scan chain length, >=2).
REQ-002 SHALL have parameter SIG_W, default 8, response signature width (fixed polynomial below requires 8).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a test run; sampled only in IDLE.
REQ-006 SHALL have port num_patterns  input  8  patterns to apply; sampled with start.
REQ-007 SHALL have port scan_in  input  1  serial pattern bit, consumed each SHIFT cycle.
REQ-008 SHALL have port ppo  input  CHAIN_LEN  pseudo-primary outputs of the combinational core (ppo[1]=B, ppo[0]=C for CHAIN_LEN=2).
REQ-009 SHALL have port ppi  output  CHAIN_LEN  chain contents driving core pseudo-primary inputs (ppi[1]=qB, ppi[0]=qC).
REQ-010 SHALL have port scan_en  output  1  high in SHIFT and UNLOAD states.
REQ-011 SHALL have port scan_out  output  1  chain[CHAIN_LEN-1], combinational from chain register.
REQ-012 SHALL have port busy  output  1  high in SHIFT, CAPTURE, UNLOAD.
REQ-013 SHALL have port done  output  1  one-cycle pulse in DONE state.
REQ-014 SHALL have port signature  output  SIG_W  MISR response signature; stable from DONE until next accepted start.

Function
REQ-015 SHALL implement FSM states IDLE, SHIFT, CAPTURE, UNLOAD, DONE.
REQ-016 IDLE: start=1 and num_patterns>0 -> SHIFT, load pattern counter, clear signature, clear shift counter, clear capture_seen flag.
REQ-017 IDLE: start=1 and num_patterns=0 -> DONE directly, signature cleared to 0.
REQ-018 SHIFT: exactly CHAIN_LEN cycles; each cycle chain <= {chain[CHAIN_LEN-2:0], scan_in}; then -> CAPTURE.
REQ-019 CAPTURE: exactly one cycle, scan_en=0, chain <= ppo, pattern counter decrements, capture_seen set; -> SHIFT if counter after decrement >0, else -> UNLOAD.
REQ-020 UNLOAD: exactly CHAIN_LEN cycles shifting as SHIFT but with 0 shifted in (scan_in ignored); then -> DONE.
REQ-021 DONE: one cycle, done=1; -> IDLE unconditionally.
REQ-022 MISR SHALL update on every SHIFT cycle with capture_seen=1 and every UNLOAD cycle: sig <= {sig[6:0],1'b0} ^ (sig[7] ? 8'h1D : 8'h00) ^ {7'b0, scan_out} (polynomial x^8+x^4+x^3+x^2+1), using scan_out before the shift.
REQ-023 MISR SHALL NOT update on the first pattern load, in CAPTURE, IDLE or DONE.
REQ-024 start SHALL be ignored whenever state is not IDLE; num_patterns changes mid-run SHALL have no effect.
REQ-025 Total run length from start-sample edge to done pulse SHALL be num_patterns*(CHAIN_LEN+1)+CHAIN_LEN cycles, done asserted in the following cycle.
REQ-026 ppi SHALL equal chain at all times (including during shift; core output is only captured in CAPTURE).

Reset
REQ-027 rst_n=0 SHALL immediately force state IDLE, chain=0, ppi=0, scan_en=0, busy=0, done=0, signature=0, counters=0.
REQ-028 Reset asserted mid-run SHALL abort the run with no done pulse; first start after release begins a fresh run.

Verification
REQ-029 CHAIN_LEN=2, num_patterns=1, scan_in=1 then 0, core A=1,H_0=1 (ppo=2'b10) -> ppi=2'b10 after SHIFT, scan_out 1 then 0 in UNLOAD, signature=8'h02, done 6 cycles after start edge.
REQ-030 num_patterns=0, start pulse -> done next cycle, busy never high, signature=8'h00.
REQ-031 num_patterns=3, pattern stream 2'b01, 2'b11, 2'b00 with core response fed back -> 3 CAPTURE cycles, busy high 11 cycles, signature matches reference MISR model.
REQ-032 start re-pulsed during SHIFT and UNLOAD -> no restart, done pulses exactly once.
REQ-033 rst_n pulsed low during second SHIFT of a 2-pattern run -> all outputs 0 same cycle, no done; subsequent run with num_patterns=1 yields REQ-029 result.
REQ-034 Stuck fault H_0=0 vs H_0=1 with identical patterns -> differing signatures.
